// File: rtl/geometry_residual_encoder.sv
// Encoder side of the LiDAR geometry saturating adder: emits per-axis residuals
// sat(point - pred) against the previous reconstructed point, with valid/ready on both sides.
module geometry_residual_encoder #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [95:0]       in_point,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [95:0]       out_res,
    output logic              out_sof,
    output logic [2:0]        out_sat,
    output logic [CNT_W-1:0]  point_cnt,
    output logic [CNT_W-1:0]  sat_cnt
);
    localparam int DATA_W = 32;
    localparam int AXES   = 3;

    function automatic logic signed [DATA_W-1:0] sat_clamp(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + 1'b1 : c;
    endfunction

    logic signed [DATA_W-1:0] pred_p0  [AXES];
    logic signed [DATA_W-1:0] pt_c     [AXES];
    logic signed [DATA_W-1:0] pe_c     [AXES];
    logic signed [DATA_W:0]   d_c      [AXES];
    logic signed [DATA_W-1:0] res_c    [AXES];
    logic signed [DATA_W-1:0] recon_c  [AXES];
    logic        [AXES-1:0]   sat_c;

    logic [AXES*DATA_W-1:0]   res_p0;
    logic                     vld_p0;
    logic                     sof_p0;
    logic [AXES-1:0]          sat_p0;
    logic [CNT_W-1:0]         point_cnt_p0;
    logic [CNT_W-1:0]         sat_cnt_p0;
    logic                     accept;

    assign in_ready = !vld_p0 || out_ready;
    assign accept   = in_valid && in_ready;

    // Residual and reconstruction; a frame start codes against a zero predictor.
    always_comb begin
        pt_c    = '{default: '0};
        pe_c    = '{default: '0};
        d_c     = '{default: '0};
        res_c   = '{default: '0};
        recon_c = '{default: '0};
        sat_c   = '0;
        for (int a = 0; a < AXES; a++) begin
            pt_c[a]    = in_point[a*DATA_W +: DATA_W];
            pe_c[a]    = in_sof ? '0 : pred_p0[a];
            d_c[a]     = {pt_c[a][DATA_W-1], pt_c[a]} - {pe_c[a][DATA_W-1], pe_c[a]};
            res_c[a]   = sat_clamp(d_c[a]);
            sat_c[a]   = (d_c[a] != {res_c[a][DATA_W-1], res_c[a]});
            recon_c[a] = sat_clamp({pe_c[a][DATA_W-1], pe_c[a]} + {res_c[a][DATA_W-1], res_c[a]});
        end
    end

    // Stage p0: output register, predictor and frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0       <= 1'b0;
            res_p0       <= '0;
            sof_p0       <= 1'b0;
            sat_p0       <= '0;
            point_cnt_p0 <= '0;
            sat_cnt_p0   <= '0;
            for (int a = 0; a < AXES; a++) pred_p0[a] <= '0;
        end else if (accept) begin
            vld_p0 <= 1'b1;
            sof_p0 <= in_sof;
            sat_p0 <= sat_c;
            for (int a = 0; a < AXES; a++) begin
                res_p0[a*DATA_W +: DATA_W] <= res_c[a];
                pred_p0[a]                 <= recon_c[a];
            end
            if (in_sof) begin
                point_cnt_p0 <= CNT_W'(1);
                sat_cnt_p0   <= CNT_W'(|sat_c);
            end else begin
                point_cnt_p0 <= cnt_inc(point_cnt_p0, 1'b1);
                sat_cnt_p0   <= cnt_inc(sat_cnt_p0, |sat_c);
            end
        end else if (out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid = vld_p0;
    assign out_res   = res_p0;
    assign out_sof   = sof_p0;
    assign out_sat   = sat_p0;
    assign point_cnt = point_cnt_p0;
    assign sat_cnt   = sat_cnt_p0;

endmodule

// File: tb/tb_geometry_residual_encoder.sv
// Scoreboard bench for geometry_residual_encoder: integer reference model feeds a queue,
// a monitor pops on every output handshake and also runs a decoder-side reconstruction.
module tb_geometry_residual_encoder;
    localparam int CNT_W = 16;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [95:0]      in_point;
    logic             in_sof;
    logic             out_valid;
    logic             out_ready;
    logic [95:0]      out_res;
    logic             out_sof;
    logic [2:0]       out_sat;
    logic [CNT_W-1:0] point_cnt;
    logic [CNT_W-1:0] sat_cnt;

    geometry_residual_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_point(in_point), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_sof(out_sof), .out_sat(out_sat),
        .point_cnt(point_cnt), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] res;
        logic        sof;
        logic [2:0]  sat;
        logic [95:0] pt;
    } exp_t;

    exp_t   sb[$];
    int     total = 0, bad = 0;
    int     accepts = 0, outputs = 0, dropped = 0;
    longint mpred[3];
    longint dpred[3];
    int     pcnt = 0, scnt = 0;
    bit     rand_rdy = 1'b0;

    function automatic longint clampl(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic logic [95:0] pack(input int x, input int y, input int z);
        return {x, y, z};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: per-axis integer arithmetic straight from the residual/recon rules.
    task automatic model_accept(input logic [95:0] pt, input logic sof);
        exp_t   e;
        longint p, pe, d, r;
        e.pt  = pt;
        e.sof = sof;
        e.res = '0;
        e.sat = '0;
        for (int a = 0; a < 3; a++) begin
            p  = longint'($signed(pt[a*32 +: 32]));
            pe = sof ? 0 : mpred[a];
            d  = p - pe;
            r  = clampl(d);
            e.res[a*32 +: 32] = r[31:0];
            e.sat[a] = (d != r);
            mpred[a] = clampl(pe + r);
        end
        if (sof) begin
            pcnt = 1;
            scnt = (|e.sat) ? 1 : 0;
        end else begin
            if (pcnt < 65535) pcnt++;
            if ((|e.sat) && scnt < 65535) scnt++;
        end
        sb.push_back(e);
    endtask

    task automatic reset_model();
        for (int a = 0; a < 3; a++) begin
            mpred[a] = 0;
            dpred[a] = 0;
        end
        pcnt = 0;
        scnt = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [95:0] pt, input logic sof);
        in_valid = 1'b1;
        in_point = pt;
        in_sof   = sof;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(pt, sof);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                accepts++;
                check("point_cnt", 96'(point_cnt), 96'(pcnt));
                check("sat_cnt", 96'(sat_cnt), 96'(scnt));
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: a handshake seen at the negedge completes at the following posedge.
    always @(negedge clk) begin
        exp_t   e;
        longint pe, rec;
        if (!rst && out_valid && out_ready) begin
            outputs++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got res %h expected no output", out_res);
            end else begin
                e = sb.pop_front();
                check("out_res", out_res, e.res);
                check("out_sof", 96'(out_sof), 96'(e.sof));
                check("out_sat", 96'(out_sat), 96'(e.sat));
                for (int a = 0; a < 3; a++) begin
                    pe  = out_sof ? 0 : dpred[a];
                    rec = clampl(pe + longint'($signed(out_res[a*32 +: 32])));
                    dpred[a] = rec;
                    if (!out_sat[a]) check("decoder_recon", 96'(rec[31:0]), 96'(e.pt[a*32 +: 32]));
                end
            end
        end
    end

    initial begin
        logic [95:0] hold;
        logic [95:0] p;
        rst = 1'b1;
        in_valid = 1'b0;
        in_point = '0;
        in_sof = 1'b0;
        out_ready = 1'b1;
        reset_model();
        idle(2);
        rst = 1'b0;
        idle(1);
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_out_res", out_res, 96'(0));
        check("rst_out_sof", 96'(out_sof), 96'(0));
        check("rst_out_sat", 96'(out_sat), 96'(0));
        check("rst_point_cnt", 96'(point_cnt), 96'(0));
        check("rst_sat_cnt", 96'(sat_cnt), 96'(0));
        check("rst_in_ready", 96'(in_ready), 96'(1));

        // Basic frame
        send(pack(10, -5, 7), 1'b1);
        check("t1_res0", out_res, pack(10, -5, 7));
        check("t1_sof0", 96'(out_sof), 96'(1));
        send(pack(12, -5, 0), 1'b0);
        check("t1_res1", out_res, pack(2, 0, -7));
        check("t1_sat1", 96'(out_sat), 96'(0));
        check("t1_pcnt", 96'(point_cnt), 96'(2));
        idle(2);

        // Saturation; predictor follows reconstruction (-1), not the raw point
        send(pack(int'(SMIN), 0, 0), 1'b1);
        send(pack(int'(SMAX), 0, 0), 1'b0);
        check("t2_res", out_res, pack(int'(SMAX), 0, 0));
        check("t2_sat", 96'(out_sat), 96'(3'b100));
        check("t2_satcnt", 96'(sat_cnt), 96'(1));
        send(pack(0, 0, 0), 1'b0);
        check("t2_res_next", out_res, pack(1, 0, 0));
        idle(2);

        // Backpressure with no bubble on release
        out_ready = 1'b0;
        send(pack(50, 60, 70), 1'b0);
        hold = out_res;
        in_valid = 1'b1;
        in_point = pack(55, 66, 77);
        in_sof = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 96'(in_ready), 96'(0));
            check("bp_hold", out_res, hold);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(pack(55, 66, 77), 1'b0);
        check("bp_no_bubble", 96'(out_valid), 96'(1));
        check("bp_res", out_res, pack(5, 6, 7));
        idle(2);

        // Mid-frame sof discards the predictor
        send(pack(100, 100, 100), 1'b0);
        send(pack(3, 4, 5), 1'b1);
        check("sof_res", out_res, pack(3, 4, 5));
        check("sof_pcnt", 96'(point_cnt), 96'(1));
        check("sof_satcnt", 96'(sat_cnt), 96'(0));
        idle(2);

        // Random streaming with random downstream readiness
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(0, 3))
                0: p = {$urandom(), $urandom(), $urandom()};
                1: p = pack(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
                            int'($urandom_range(0, 2000)) - 1000);
                2: p = pack(($urandom_range(0, 1) != 0) ? int'(SMAX) : int'(SMIN), int'($urandom()), 0);
                default: p = pack(int'($urandom_range(0, 100)), -int'($urandom_range(0, 100)), 42);
            endcase
            send(p, ($urandom_range(0, 15) == 0));
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("stream_drained", 96'(sb.size()), 96'(0));

        // Async reset while an output is held
        out_ready = 1'b0;
        send(pack(9, 9, 9), 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 96'(out_valid), 96'(0));
        dropped += sb.size();
        sb.delete();
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(pack(1, 1, 1), 1'b0);
        check("arst_res", out_res, pack(1, 1, 1));
        idle(3);

        check("queue_empty", 96'(sb.size()), 96'(0));
        check("accept_vs_output", 96'(accepts), 96'(outputs + dropped));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/geometry_residual_encoder.md
Name: geometry_residual_encoder

Overview:
- Encoder-side counterpart of the geometry decompressor's saturating adder stage in the LiDAR geometry path.
- Accepts a stream of 3-axis signed 32-bit points and emits per-axis residuals r = sat(point - pred).
- pred is the previous *reconstructed* point, so the decoder's sat(pred + r) stays bit-exact with the encoder even when saturation occurs.
- Single-entry registered output with valid/ready on both sides; sits between point capture and the entropy-coding stage.

Parameters:
CNT_W, 16, width of point_cnt and sat_cnt status counters (both saturate at 2^CNT_W-1)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input point valid
in_ready  out  1  input point accepted when in_valid && in_ready
in_point  in  96  signed point: x=[95:64], y=[63:32], z=[31:0]
in_sof  in  1  start of frame; qualifies with in_valid; predictor treated as zero for this point
out_valid  out  1  residual valid
out_ready  in  1  downstream ready
out_res  out  96  signed residual, same packing as in_point
out_sof  out  1  sof of the point that produced out_res
out_sat  out  3  per-axis saturation flags {x,y,z} for out_res
point_cnt  out  CNT_W  points accepted in current frame
sat_cnt  out  CNT_W  accepted points in current frame with any out_sat bit set

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_res=0, out_sof=0, out_sat=0, pred=0 on all axes, point_cnt=0, sat_cnt=0. in_ready=1 after reset.
- in_ready = !out_valid || out_ready (combinational). No combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept at edge N, the output register loads and out_valid=1 from cycle N+1. Latency is 1 cycle; throughput is 1 point/cycle when out_ready is held high.
- Output hold: while out_valid && !out_ready, out_res/out_sof/out_sat are stable and no input is accepted.
- Drain: out_valid clears on out_ready with no simultaneous accept. Simultaneous drain and accept reloads the output register, and out_valid stays 1.
- Per-axis arithmetic:
  - p_eff = in_sof ? 0 : pred.
  - d = sign-extended 33-bit (point - p_eff).
  - r = clamp(d, -2^31, 2^31-1); sat bit = (d != r).
  - recon = clamp(33-bit p_eff + r, -2^31, 2^31-1).
  - On accept, pred <= recon. recon equals point unless sat is set.
- Frame counters, on accept:
  - in_sof=1: point_cnt <= 1; sat_cnt <= (|sat ? 1 : 0).
  - Otherwise: point_cnt +1 and sat_cnt +(|sat), each saturating at all-ones.
- in_sof while pred is nonzero discards the old predictor; no other frame-end signalling.
- in_point/in_sof are ignored when not accepted; no state changes.
- Reset mid-stream: the pending output is dropped, the predictor clears, and the next accepted point is coded against zero regardless of in_sof.

Test Plan:
- Reset, then accept sof point (10,-5,7) and then (12,-5,0) with out_ready=1 -> out_res (10,-5,7) out_sof=1, then (2,0,-7) out_sof=0, out_sat=0 both; point_cnt=2, sat_cnt=0.
- Saturation: sof point (-2^31,0,0), then (2^31-1,0,0) -> second out_res.x=2^31-1, out_sat=100, sat_cnt=1. Third point (0,0,0) -> out_res.x=1, because pred is recon -1, not 2^31-1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept, out_res stable. Release -> next point accepted in the same cycle the held residual drains, with no bubble.
- Back-to-back streaming of 100 random points with random out_ready -> software model of sat(pred+res) on out_res reproduces every non-saturated input exactly. Count of outputs equals count of accepts.
- Mid-frame sof: after pred=(100,100,100), sof point (3,4,5) -> out_res (3,4,5), point_cnt=1, sat_cnt=0.
- Async reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately (no clock needed). After release, point (1,1,1) with in_sof=0 -> out_res (1,1,1).
